batchnorm_affine: RTL and testbench

BATCHNORM_AFFINE -- requirements
Module: batchnorm_affine

---
 rtl/batchnorm_affine.sv | 125 ++++++++++++
 tb/tb_batchnorm_affine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batchnorm_affine.sv
// Folded batch-norm affine stage: y = sat(round(x*scale) + bias) per channel.
// Two-stage valid/ready pipeline with resettable per-channel coefficient registers.
module batchnorm_affine #(
    parameter int dataWidth = 16,
    parameter int fracWidth = 8,
    parameter int NUM_CH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [dataWidth-1:0]  x_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic                         ch_clear,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]    cfg_addr,
    input  logic signed [dataWidth-1:0]  cfg_scale,
    input  logic signed [dataWidth-1:0]  cfg_bias,
    output logic signed [dataWidth-1:0]  y_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [$clog2(NUM_CH)-1:0]    ch_out
);

    localparam int W  = dataWidth;
    localparam int PW = 2 * dataWidth;
    localparam int AW = $clog2(NUM_CH);

    localparam logic [AW:0]            CH_NUM  = (AW+1)'(NUM_CH);
    localparam logic [AW-1:0]          CH_LAST = AW'(NUM_CH - 1);
    localparam logic signed [W-1:0]    ONE     = W'(1 << fracWidth);
    localparam logic signed [PW-1:0]   HALF    = PW'(1 << (fracWidth - 1));
    localparam logic signed [W-1:0]    SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]    SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0]  scale_q [NUM_CH];
    logic signed [W-1:0]  bias_q  [NUM_CH];
    logic [AW-1:0]        ch_cnt;
    logic [AW-1:0]        ch_sel;

    logic                 v1;
    logic signed [PW-1:0] prod_q;
    logic signed [W-1:0]  bias1_q;
    logic [AW-1:0]        ch1_q;

    logic                 adv1;
    logic                 adv2;
    logic                 accept;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] rnd;
    logic signed [PW:0]   sum;
    logic signed [W-1:0]  sat;
    logic                 ovf;

    assign adv2      = !valid_out || ready_in;
    assign adv1      = !v1 || adv2;
    assign ready_out = adv1;
    assign accept    = valid_in && adv1;

    // ch_clear applies to a sample accepted in the same cycle
    assign ch_sel = ch_clear ? '0 : ch_cnt;
    assign prod_d = PW'(x_in) * PW'(scale_q[ch_sel]);

    // Full-width sum so saturation sees the true value, not a wrapped one
    assign rnd = (prod_q + HALF) >>> fracWidth;
    assign sum = (PW+1)'(rnd) + (PW+1)'(bias1_q);
    assign ovf = !((&sum[PW:W-1]) || !(|sum[PW:W-1]));

    always_comb begin
        sat = sum[W-1:0];
        if (ovf) begin
            sat = sum[PW] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i] <= ONE;
                bias_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                ch_cnt <= (ch_sel == CH_LAST) ? '0 : ch_sel + AW'(1);
            end else if (ch_clear) begin
                ch_cnt <= '0;
            end
            if (cfg_we && ({1'b0, cfg_addr} < CH_NUM)) begin
                scale_q[cfg_addr] <= cfg_scale;
                bias_q[cfg_addr]  <= cfg_bias;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            prod_q  <= '0;
            bias1_q <= '0;
            ch1_q   <= '0;
        end else if (adv1) begin
            v1 <= accept;
            if (accept) begin
                prod_q  <= prod_d;
                bias1_q <= bias_q[ch_sel];
                ch1_q   <= ch_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            y_out     <= '0;
            ch_out    <= '0;
        end else if (adv2) begin
            valid_out <= v1;
            if (v1) begin
                y_out  <= sat;
                ch_out <= ch1_q;
            end
        end
    end

endmodule

// File: tb/tb_batchnorm_affine.sv
// Bench for batchnorm_affine: directed literal cases plus randomized
// backpressure, all checked against an arithmetic reference model.
module tb_batchnorm_affine;

    localparam int W   = 16;
    localparam int F   = 8;
    localparam int NCH = 16;
    localparam int AW  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] x_in;
    logic                valid_in;
    logic                ready_out;
    logic                ch_clear;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic signed [W-1:0] cfg_scale;
    logic signed [W-1:0] cfg_bias;
    logic signed [W-1:0] y_out;
    logic                valid_out;
    logic                ready_in;
    logic [AW-1:0]       ch_out;

    batchnorm_affine #(
        .dataWidth(W),
        .fracWidth(F),
        .NUM_CH(NCH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x_in(x_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .ch_clear(ch_clear),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_scale(cfg_scale),
        .cfg_bias(cfg_bias),
        .y_out(y_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .ch_out(ch_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  ch;
    } item_t;

    int      tests = 0;
    int      fails = 0;
    shortint m_scale [NCH];
    shortint m_bias  [NCH];
    int      m_cnt;
    item_t   exp_q[$];
    item_t   obs_q[$];
    logic        prev_stall;
    logic [15:0] prev_y;
    logic [3:0]  prev_ch;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input shortint x,
                                          input shortint s,
                                          input shortint b);
        longint r;
        longint t;
        r = (longint'(x) * longint'(s) + (longint'(1) << (F - 1))) >>> F;
        t = r + longint'(b);
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return 16'(t);
    endfunction

    task automatic m_reset();
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_scale[i] = shortint'(1 << F);
            m_bias[i]  = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_reset();
            prev_stall = 1'b0;
            chk("rst_valid_out", {31'b0, valid_out}, 0);
            chk("rst_ready_out", {31'b0, ready_out}, 1);
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, valid_out}, 1);
                chk("hold_y", {16'b0, y_out}, {16'b0, prev_y});
                chk("hold_ch", {28'b0, ch_out}, {28'b0, prev_ch});
            end
            chk("ready_out", {31'b0, ready_out},
                (exp_q.size() >= 2 && !ready_in) ? 0 : 1);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    item_t e;
                    e = exp_q.pop_front();
                    chk("model_y", {16'b0, y_out}, {16'b0, e.y});
                    chk("model_ch", {28'b0, ch_out}, {28'b0, e.ch});
                end
                obs_q.push_back('{y_out, ch_out});
            end
            prev_stall = valid_out && !ready_in;
            prev_y     = y_out;
            prev_ch    = ch_out;
            if (valid_in && ready_out) begin
                int c;
                c = ch_clear ? 0 : m_cnt;
                exp_q.push_back('{ref_y(x_in, m_scale[c], m_bias[c]), 4'(c)});
                m_cnt = (c + 1) % NCH;
            end else if (ch_clear) begin
                m_cnt = 0;
            end
            if (cfg_we && int'(cfg_addr) < NCH) begin
                m_scale[cfg_addr] = cfg_scale;
                m_bias[cfg_addr]  = cfg_bias;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [15:0] s, input logic [15:0] b);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(ch);
        cfg_scale = s;
        cfg_bias  = b;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send_check(input string nm, input logic [15:0] x,
                              input logic clr, input logic [15:0] ey,
                              input logic [3:0] ech);
        int n;
        ready_in = 1'b1;
        valid_in = 1'b1;
        x_in     = x;
        ch_clear = clr;
        step();
        valid_in = 1'b0;
        ch_clear = 1'b0;
        for (n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (valid_out) break;
        end
        chk({nm, "_latency"}, n, 2);
        chk({nm, "_y"}, {16'b0, y_out}, {16'b0, ey});
        chk({nm, "_ch"}, {28'b0, ch_out}, {28'b0, ech});
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        x_in = '0; valid_in = 1'b0; ch_clear = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_bias = '0;
        ready_in = 1'b1;
        m_reset();
        repeat (2) step();
        chk("reset_y", {16'b0, y_out}, 0);
        chk("reset_ch", {28'b0, ch_out}, 0);
        chk("reset_valid", {31'b0, valid_out}, 0);
        chk("reset_ready", {31'b0, ready_out}, 1);
        rst = 1'b1;
        step();

        cfg(0, 16'h0180, 16'h0080);
        cfg(1, 16'h0200, 16'h0000);
        cfg(2, 16'h0200, 16'h0000);
        cfg(3, 16'h0100, 16'hFFC0);
        cfg(4, 16'h0080, 16'h0000);
        cfg(5, 16'h0080, 16'h0000);
        send_check("basic", 16'h0200, 1'b0, 16'h0380, 4'd0);
        send_check("sat_hi", 16'h7F00, 1'b0, 16'h7FFF, 4'd1);
        send_check("sat_lo", 16'h8100, 1'b0, 16'h8000, 4'd2);
        send_check("neg", 16'hFF00, 1'b0, 16'hFEC0, 4'd3);
        send_check("rnd_pos", 16'h0001, 1'b0, 16'h0001, 4'd4);
        send_check("rnd_neg", 16'hFFFF, 1'b0, 16'h0000, 4'd5);

        for (int i = 0; i < NCH; i++) cfg(i, 16'h0100, 16'(i * 16));
        ch_clear = 1'b1;
        step();
        ch_clear = 1'b0;
        obs_q.delete();
        valid_in = 1'b1;
        x_in = '0;
        repeat (20) step();
        valid_in = 1'b0;
        repeat (4) step();
        chk("wrap_count", obs_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < obs_q.size()) begin
                chk("wrap_ch", {28'b0, obs_q[i].ch}, i % 16);
                chk("wrap_y", {16'b0, obs_q[i].y}, (i % 16) * 16);
            end
        end
        send_check("clear21", 16'h0000, 1'b1, 16'h0000, 4'd0);

        obs_q.delete();
        x_in = 16'h0100;
        valid_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ch_clear  = (k == 0 || k == 4);
            cfg_we    = (k == 3);
            cfg_addr  = 4'd3;
            cfg_scale = 16'h0200;
            cfg_bias  = 16'h0000;
            step();
        end
        valid_in = 1'b0; ch_clear = 1'b0; cfg_we = 1'b0;
        repeat (4) step();
        chk("cfg_count", obs_q.size(), 8);
        if (obs_q.size() == 8) begin
            chk("cfg_old_y", {16'b0, obs_q[3].y}, 16'h0130);
            chk("cfg_old_ch", {28'b0, obs_q[3].ch}, 3);
            chk("cfg_new_y", {16'b0, obs_q[7].y}, 16'h0200);
            chk("cfg_new_ch", {28'b0, obs_q[7].ch}, 3);
        end

        ready_in = 1'b0;
        valid_in = 1'b1;
        x_in = 16'h0100;
        step();
        step();
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, valid_out}, 0);
        chk("midrst_y", {16'b0, y_out}, 0);
        chk("midrst_ch", {28'b0, ch_out}, 0);
        chk("midrst_ready", {31'b0, ready_out}, 1);
        repeat (2) step();
        rst = 1'b1;
        ready_in = 1'b1;
        step();
        obs_q.delete();
        valid_in = 1'b1;
        x_in = 16'h0123;
        repeat (NCH) step();
        valid_in = 1'b0;
        repeat (4) step();
        chk("postrst_count", obs_q.size(), NCH);
        for (int i = 0; i < NCH; i++) begin
            if (i < obs_q.size()) begin
                chk("postrst_y", {16'b0, obs_q[i].y}, 16'h0123);
                chk("postrst_ch", {28'b0, obs_q[i].ch}, i);
            end
        end

        for (int i = 0; i < 200; i++) begin
            valid_in  = 1'b1;
            x_in      = 16'($urandom);
            ready_in  = 1'($urandom % 2);
            cfg_we    = ($urandom % 8 == 0);
            cfg_addr  = 4'($urandom);
            cfg_scale = 16'($urandom);
            cfg_bias  = 16'($urandom);
            ch_clear  = ($urandom % 16 == 0);
            step();
        end
        valid_in = 1'b0; cfg_we = 1'b0; ch_clear = 1'b0;
        ready_in = 1'b1;
        repeat (6) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
